// File: rtl/regfile_write_arbiter.sv
// Two-source writeback arbiter for a 16-entry register file: one holding buffer per
// source, oldest-first grant, registered one-hot write enable and a pending-write scoreboard.
module regfile_write_arbiter #(
   parameter int NUM_REGS    = 16,
   parameter int DATA_W      = 16,
   parameter bit TIE_PRIO_B  = 1'b1,
   parameter bit ZERO_REG_RO = 1'b1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                a_valid,
   output logic                a_ready,
   input  logic [3:0]          a_reg,
   input  logic [DATA_W-1:0]   a_data,
   input  logic                b_valid,
   output logic                b_ready,
   input  logic [3:0]          b_reg,
   input  logic [DATA_W-1:0]   b_data,
   output logic [NUM_REGS-1:0] WriteReg,
   output logic [DATA_W-1:0]   D,
   output logic [NUM_REGS-1:0] pending,
   output logic [15:0]         stall_cnt
);

   logic              hold_a_valid, hold_b_valid;
   logic [3:0]        hold_a_reg, hold_b_reg;
   logic [DATA_W-1:0] hold_a_data, hold_b_data;
   logic              b_first;

   logic              grant_a, grant_b, load_a, load_b, keep_a, keep_b;
   logic              issue, stall;
   logic [3:0]        grant_reg;
   logic [DATA_W-1:0] grant_data;

   function automatic logic [NUM_REGS-1:0] onehot(input logic [3:0] r);
      onehot = NUM_REGS'(1) << r;
   endfunction

   // Writes to a read-only register 0 are swallowed: never issued, never pending.
   function automatic logic live(input logic v, input logic [3:0] r);
      live = v && !(ZERO_REG_RO && (r == 4'd0));
   endfunction

   // b_first marks hold B as the older entry; it only matters while both holds are full.
   always_comb begin
      grant_a    = hold_a_valid && (!hold_b_valid || !b_first);
      grant_b    = hold_b_valid && (!hold_a_valid || b_first);
      a_ready    = !hold_a_valid || grant_a;
      b_ready    = !hold_b_valid || grant_b;
      load_a     = a_valid && a_ready;
      load_b     = b_valid && b_ready;
      keep_a     = hold_a_valid && !grant_a;
      keep_b     = hold_b_valid && !grant_b;
      grant_reg  = grant_b ? hold_b_reg : hold_a_reg;
      grant_data = grant_b ? hold_b_data : hold_a_data;
      issue      = (grant_a || grant_b) && live(1'b1, grant_reg);
      stall      = (a_valid && !a_ready) || (b_valid && !b_ready);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_a_valid <= 1'b0;
         hold_b_valid <= 1'b0;
         hold_a_reg   <= '0;
         hold_b_reg   <= '0;
         hold_a_data  <= '0;
         hold_b_data  <= '0;
         b_first      <= 1'b0;
         WriteReg     <= '0;
         D            <= '0;
         stall_cnt    <= '0;
      end else begin
         hold_a_valid <= load_a || keep_a;
         hold_b_valid <= load_b || keep_b;
         if (load_a) begin
            hold_a_reg  <= a_reg;
            hold_a_data <= a_data;
         end
         if (load_b) begin
            hold_b_reg  <= b_reg;
            hold_b_data <= b_data;
         end
         // A side that loads while the other side stays held is the younger one.
         if (load_a && load_b)
            b_first <= TIE_PRIO_B;
         else if (load_b && keep_a)
            b_first <= 1'b0;
         else if (load_a && keep_b)
            b_first <= 1'b1;
         WriteReg <= issue ? onehot(grant_reg) : '0;
         if (issue)
            D <= grant_data;
         if (stall && (stall_cnt != 16'hFFFF))
            stall_cnt <= stall_cnt + 16'd1;
      end
   end

   assign pending = (live(hold_a_valid, hold_a_reg) ? onehot(hold_a_reg) : '0)
                  | (live(hold_b_valid, hold_b_reg) ? onehot(hold_b_reg) : '0)
                  | WriteReg;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: expected writes are queued as stimulus
// is driven and compared whenever the write port fires.
module tb_regfile_write_arbiter;

   logic        clock = 1'b0;
   logic        rst;
   logic        a_valid, b_valid;
   logic [3:0]  a_reg, b_reg;
   logic [15:0] a_data, b_data;
   logic        a_ready, b_ready, a_ready1, b_ready1;
   logic [15:0] WriteReg, D, pending, stall_cnt;
   logic [15:0] WriteReg1, D1, pending1, stall_cnt1;

   typedef struct packed {
      logic [15:0] we;
      logic [15:0] d;
   } write_t;

   write_t sb[$];
   int     testsRun = 0;
   int     testsFailed = 0;
   logic   monEn = 1'b1;

   regfile_write_arbiter #(.TIE_PRIO_B(1'b1)) dut (
      .clk(clock), .rst(rst),
      .a_valid(a_valid), .a_ready(a_ready), .a_reg(a_reg), .a_data(a_data),
      .b_valid(b_valid), .b_ready(b_ready), .b_reg(b_reg), .b_data(b_data),
      .WriteReg(WriteReg), .D(D), .pending(pending), .stall_cnt(stall_cnt)
   );

   regfile_write_arbiter #(.TIE_PRIO_B(1'b0)) dutA (
      .clk(clock), .rst(rst),
      .a_valid(a_valid), .a_ready(a_ready1), .a_reg(a_reg), .a_data(a_data),
      .b_valid(b_valid), .b_ready(b_ready1), .b_reg(b_reg), .b_data(b_data),
      .WriteReg(WriteReg1), .D(D1), .pending(pending1), .stall_cnt(stall_cnt1)
   );

   always #5 clock = ~clock;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      testsRun++;
      if (got !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic applyStimulus(input logic av, input logic [3:0] ar, input logic [15:0] ad,
                                input logic bv, input logic [3:0] br, input logic [15:0] bd);
      a_valid = av; a_reg = ar; a_data = ad;
      b_valid = bv; b_reg = br; b_data = bd;
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic pushWrite(input logic [3:0] r, input logic [15:0] d);
      write_t w;
      w.we = 16'h1 << r;
      w.d  = d;
      sb.push_back(w);
   endtask

   task automatic doReset();
      applyStimulus(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   // Every issued write must match the oldest outstanding expectation.
   always @(negedge clock) begin
      if (monEn && !rst && (WriteReg != 16'h0)) begin
         if (sb.size() == 0)
            checkOutput("sb_unexpected_write", {16'h0, WriteReg}, 32'h0);
         else begin
            write_t w;
            w = sb.pop_front();
            checkOutput("sb_we", {16'h0, WriteReg}, {16'h0, w.we});
            checkOutput("sb_d", {16'h0, D}, {16'h0, w.d});
         end
      end
   end

   initial begin
      int aIdx, bIdx, cyc;
      logic aAcc, bAcc;

      applyStimulus(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
      rst = 1'b1;
      #12;
      tick();
      rst = 1'b0;
      checkOutput("reset_we", {16'h0, WriteReg}, 32'h0);
      checkOutput("reset_d", {16'h0, D}, 32'h0);
      checkOutput("reset_ready", {30'h0, a_ready, b_ready}, 32'h3);

      // Asynchronous reset in the middle of a cycle with both holds full
      monEn = 1'b0;
      applyStimulus(1'b1, 4'd1, 16'h1111, 1'b1, 4'd2, 16'h2222);
      tick(); tick(); tick();
      #3;
      applyStimulus(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
      rst = 1'b1;
      #1;
      checkOutput("async_rst_we", {16'h0, WriteReg}, 32'h0);
      checkOutput("async_rst_pending", {16'h0, pending}, 32'h0);
      checkOutput("async_rst_stall", {16'h0, stall_cnt}, 32'h0);
      tick();
      rst = 1'b0;
      checkOutput("rst_release_ready", {30'h0, a_ready, b_ready}, 32'h3);
      monEn = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         checkOutput("post_rst_we", {16'h0, WriteReg}, 32'h0);
      end

      // Single write from A
      doReset();
      applyStimulus(1'b1, 4'd5, 16'h1234, 1'b0, 4'd0, 16'h0);
      pushWrite(4'd5, 16'h1234);
      tick();
      applyStimulus(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
      checkOutput("single_pend_e0", {16'h0, pending}, 32'h0020);
      checkOutput("single_we_e0", {16'h0, WriteReg}, 32'h0);
      tick();
      checkOutput("single_we_e1", {16'h0, WriteReg}, 32'h0020);
      checkOutput("single_d_e1", {16'h0, D}, 32'h1234);
      checkOutput("single_pend_e1", {16'h0, pending}, 32'h0020);
      tick();
      checkOutput("single_we_e2", {16'h0, WriteReg}, 32'h0);
      checkOutput("single_pend_e2", {16'h0, pending}, 32'h0);

      // Same-edge contention on r3, both tie priorities
      doReset();
      applyStimulus(1'b1, 4'd3, 16'hAAAA, 1'b1, 4'd3, 16'h5555);
      pushWrite(4'd3, 16'h5555);
      pushWrite(4'd3, 16'hAAAA);
      tick();
      applyStimulus(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
      tick();
      checkOutput("tie0_first_we", {16'h0, WriteReg1}, 32'h0008);
      checkOutput("tie0_first_d", {16'h0, D1}, 32'hAAAA);
      tick();
      checkOutput("tie0_second_d", {16'h0, D1}, 32'h5555);
      checkOutput("tie1_final_d", {16'h0, D}, 32'hAAAA);
      tick();
      checkOutput("tie_idle_pend", {16'h0, pending}, 32'h0);

      // Back-to-back A writes, B idle
      doReset();
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b1, 4'(i + 1), 16'(16'hC000 + i), 1'b0, 4'd0, 16'h0);
         checkOutput("b2b_a_ready", {31'h0, a_ready}, 32'h1);
         pushWrite(4'(i + 1), 16'(16'hC000 + i));
         tick();
      end
      applyStimulus(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
      tick(); tick();
      checkOutput("b2b_stall", {16'h0, stall_cnt}, 32'h0);

      // Both sides saturating: strictly alternating, oldest first
      doReset();
      for (int i = 0; i < 5; i++) begin
         pushWrite(4'(i + 8), 16'(16'hB000 + i));
         pushWrite(4'(i + 1), 16'(16'hA000 + i));
      end
      aIdx = 0; bIdx = 0; cyc = 0;
      while ((aIdx < 5 || bIdx < 5) && cyc < 100) begin
         applyStimulus(aIdx < 5, 4'(aIdx + 1), 16'(16'hA000 + aIdx),
                       bIdx < 5, 4'(bIdx + 8), 16'(16'hB000 + bIdx));
         aAcc = a_valid && a_ready;
         bAcc = b_valid && b_ready;
         tick();
         if (aAcc) aIdx++;
         if (bAcc) bIdx++;
         cyc++;
      end
      checkOutput("sat_budget", {31'h0, cyc < 100}, 32'h1);
      applyStimulus(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
      for (int i = 0; i < 4; i++) tick();
      checkOutput("sat_stall_cnt", {16'h0, stall_cnt}, 32'd7);

      // Write to read-only r0 from B
      doReset();
      applyStimulus(1'b0, 4'd0, 16'h0, 1'b1, 4'd0, 16'hFFFF);
      checkOutput("zero_b_ready", {31'h0, b_ready}, 32'h1);
      tick();
      applyStimulus(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
      checkOutput("zero_pend_e0", {16'h0, pending}, 32'h0);
      tick();
      checkOutput("zero_we_e1", {16'h0, WriteReg}, 32'h0);
      checkOutput("zero_pend_e1", {16'h0, pending}, 32'h0);
      tick();
      checkOutput("sb_drain", sb.size(), 32'd0);

      // Sustained contention saturates the stall counter
      doReset();
      monEn = 1'b0;
      applyStimulus(1'b1, 4'd1, 16'h0101, 1'b1, 4'd2, 16'h0202);
      repeat (66000) @(posedge clock);
      #1;
      applyStimulus(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
      tick(); tick();
      checkOutput("stall_saturate", {16'h0, stall_cnt}, 32'h0000FFFF);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
